// File: rtl/hit_counter.sv
// Counts debounced ship-hit events with a frame-based invulnerability window
// after each counted hit. The count saturates and holds until a new-game clear.
module hit_counter #(
  parameter int MAX_COUNT       = 15,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hit_in,
  input  logic       frame_tick,
  output logic [3:0] signal_counter,
  output logic       hit_pulse,
  output logic       invulnerable,
  output logic       saturated
);

  localparam logic [3:0] MAX_C   = 4'(MAX_COUNT);
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);

  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] cooldown_reg, cooldown_next;
  logic [3:0] count_next;
  logic       pulse_next;
  logic       inv_next;
  logic       sat_next;
  logic       hit_in_d;
  logic       rise;

  assign rise = hit_in & ~hit_in_d;

  always_comb begin
    state_next    = state_reg;
    cooldown_next = cooldown_reg;
    count_next    = signal_counter;
    pulse_next    = 1'b0;
    inv_next      = invulnerable;

    if (clear) begin
      state_next    = READY;
      cooldown_next = 8'd0;
      count_next    = 4'd0;
      inv_next      = 1'b0;
    end else begin
      case (state_reg)
        READY: begin
          // A tick in the same cycle as the hit is ignored: the window loads full.
          if (rise) begin
            count_next    = (signal_counter >= MAX_C) ? MAX_C : signal_counter + 4'd1;
            pulse_next    = 1'b1;
            cooldown_next = CD_LOAD;
            inv_next      = 1'b1;
            state_next    = COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cooldown_reg == 8'd1) begin
              cooldown_next = 8'd0;
              inv_next      = 1'b0;
              state_next    = READY;
            end else begin
              cooldown_next = cooldown_reg - 8'd1;
            end
          end
        end
        default: state_next = READY;
      endcase
    end

    sat_next = (count_next == MAX_C);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg      <= READY;
      cooldown_reg   <= 8'd0;
      signal_counter <= 4'd0;
      hit_pulse      <= 1'b0;
      invulnerable   <= 1'b0;
      saturated      <= 1'b0;
      hit_in_d       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cooldown_reg   <= cooldown_next;
      signal_counter <= count_next;
      hit_pulse      <= pulse_next;
      invulnerable   <= inv_next;
      saturated      <= sat_next;
      // Sampled even during clear so a level held through clear is not recounted.
      hit_in_d       <= hit_in;
    end
  end

endmodule

// File: tb/tb_hit_counter.sv
// Drives two hit_counter instances (MAX_COUNT 15 and 3, window of 3 frames) with
// directed and random stimulus and compares every output against a behavioural model.
module tb_hit_counter;

  localparam int CF = 3;

  logic pclk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic hit_in = 1'b0;
  logic frame_tick = 1'b0;

  logic [3:0] cnt_o [2];
  logic       pulse_o [2];
  logic       inv_o [2];
  logic       sat_o [2];

  int n_checks = 0;
  int n_fail = 0;

  // Model: hit count, frame ticks left in the window, previous hit level, pulse.
  int m_count [2];
  int m_rem [2];
  int m_prev [2];
  int m_pulse [2];
  int pulses_seen [2];

  always #5 pclk = ~pclk;

  hit_counter #(.MAX_COUNT(15), .COOLDOWN_FRAMES(CF)) dut0 (
    .pclk(pclk), .rst(rst), .clear(clear), .hit_in(hit_in), .frame_tick(frame_tick),
    .signal_counter(cnt_o[0]), .hit_pulse(pulse_o[0]),
    .invulnerable(inv_o[0]), .saturated(sat_o[0])
  );

  hit_counter #(.MAX_COUNT(3), .COOLDOWN_FRAMES(CF)) dut1 (
    .pclk(pclk), .rst(rst), .clear(clear), .hit_in(hit_in), .frame_tick(frame_tick),
    .signal_counter(cnt_o[1]), .hit_pulse(pulse_o[1]),
    .invulnerable(inv_o[1]), .saturated(sat_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int max_of(input int i);
    return (i == 0) ? 15 : 3;
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_count[i] = 0; m_rem[i] = 0; m_prev[i] = 0; m_pulse[i] = 0;
      end else if (clear) begin
        m_count[i] = 0; m_rem[i] = 0; m_pulse[i] = 0; m_prev[i] = int'(hit_in);
      end else begin
        m_pulse[i] = 0;
        if (m_rem[i] == 0) begin
          if (hit_in && m_prev[i] == 0) begin
            m_count[i] = (m_count[i] + 1 > max_of(i)) ? max_of(i) : m_count[i] + 1;
            m_pulse[i] = 1;
            m_rem[i] = CF;
          end
        end else if (frame_tick) begin
          m_rem[i] = m_rem[i] - 1;
        end
        m_prev[i] = int'(hit_in);
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d_cnt", i), 32'(cnt_o[i]), 32'(m_count[i]));
      check($sformatf("d%0d_pulse", i), 32'(pulse_o[i]), 32'(m_pulse[i]));
      check($sformatf("d%0d_inv", i), 32'(inv_o[i]), 32'(m_rem[i] > 0));
      check($sformatf("d%0d_sat", i), 32'(sat_o[i]), 32'(m_count[i] == max_of(i)));
      if (pulse_o[i]) pulses_seen[i]++;
    end
  endtask

  task automatic step(input logic r, input logic c, input logic h, input logic t);
    rst = r; clear = c; hit_in = h; frame_tick = t;
    model_update();
    @(posedge pclk);
    @(negedge pclk);
    compare_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic hit_once();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 1);
  endtask

  initial begin
    int p0;
    logic h;
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'd1; exp_seq[1] = 4'd2; exp_seq[2] = 4'd3; exp_seq[3] = 4'd3; exp_seq[4] = 4'd3;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; m_rem[i] = 0; m_prev[i] = 0; m_pulse[i] = 0; pulses_seen[i] = 0;
    end

    // Reset then idle
    do_reset();
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
    check("idle_cnt", 32'(cnt_o[0]), 0);
    check("idle_inv", 32'(inv_o[0]), 0);

    // Single long hit with a tick every 10 cycles
    p0 = pulses_seen[0];
    for (int k = 0; k < 50; k++) begin
      step(0, 0, 1, (k % 10) == 9);
      if (k == 0) check("long_first_cnt", 32'(cnt_o[0]), 1);
      if (k == 28) check("long_inv_before_3rd", 32'(inv_o[0]), 1);
      if (k == 29) check("long_inv_after_3rd", 32'(inv_o[0]), 0);
    end
    check("long_pulses", 32'(pulses_seen[0] - p0), 1);
    check("long_final_cnt", 32'(cnt_o[0]), 1);

    // Hit during cooldown is ignored; hit after the window counts
    do_reset();
    hit_once();
    ticks(1);
    step(0, 0, 1, 0);
    check("cd_ignored_cnt", 32'(cnt_o[0]), 1);
    check("cd_ignored_pulse", 32'(pulse_o[0]), 0);
    step(0, 0, 0, 0);
    ticks(2);
    step(0, 0, 1, 0);
    check("after_window_cnt", 32'(cnt_o[0]), 2);
    step(0, 0, 0, 0);

    // Saturation on the MAX_COUNT=3 instance
    do_reset();
    p0 = pulses_seen[1];
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0);
      check("sat_seq_cnt", 32'(cnt_o[1]), 32'(exp_seq[k]));
      check("sat_seq_flag", 32'(sat_o[1]), 32'(k >= 2));
      step(0, 0, 0, 0);
      ticks(CF);
    end
    check("sat_pulses", 32'(pulses_seen[1] - p0), 5);

    // Clear together with a rise while in cooldown at count 4
    do_reset();
    for (int k = 0; k < 4; k++) begin
      hit_once();
      if (k < 3) ticks(CF);
    end
    check("pre_clear_cnt", 32'(cnt_o[0]), 4);
    step(0, 1, 1, 0);
    check("clear_cnt", 32'(cnt_o[0]), 0);
    check("clear_inv", 32'(inv_o[0]), 0);
    check("clear_pulse", 32'(pulse_o[0]), 0);
    for (int k = 0; k < 10; k++) step(0, 0, 1, (k % 3) == 0);
    check("held_after_clear_cnt", 32'(cnt_o[0]), 0);
    step(0, 0, 0, 0);

    // Reset in the middle of cooldown
    do_reset();
    hit_once();
    ticks(CF);
    hit_once();
    check("mid_cd_cnt", 32'(cnt_o[0]), 2);
    step(1, 0, 0, 0);
    check("rst_mid_cd_cnt", 32'(cnt_o[0]), 0);
    check("rst_mid_cd_inv", 32'(inv_o[0]), 0);
    step(0, 0, 1, 0);
    check("fresh_after_rst_cnt", 32'(cnt_o[0]), 1);
    step(0, 0, 0, 0);

    // Random traffic against the model
    h = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) h = ~h;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0, h,
           $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
